// File: rtl/angle_sequencer_pkg.sv
// Shared NABP configuration: angle bus geometry, sweep step and sequencer state encoding.
package angle_sequencer_pkg;

    localparam int kAngleLength = 10;
    localparam int kAngleStep   = 1;
    localparam int kAngle180    = 180;
    localparam int kAngle45     = 45;
    localparam int kAngle90     = 90;
    localparam int kAngle135    = 135;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_NEXT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/angle_sequencer.sv
// Steps the projection angle from 0 to kAngle180 (exclusive), offering each angle downstream
// and waiting for the processor to finish it before advancing.
module angle_sequencer
    import angle_sequencer_pkg::*;
#(
    parameter int kAngleLength = angle_sequencer_pkg::kAngleLength,
    parameter int kAngleStep   = angle_sequencer_pkg::kAngleStep,
    parameter int kAngle180    = angle_sequencer_pkg::kAngle180
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    proc_ready,
    input  logic                    proc_done,
    output logic [kAngleLength-1:0] angle,
    output logic                    angle_valid,
    output logic                    busy,
    output logic                    done
);

    state_t                  state;
    state_t                  state_next;
    logic [kAngleLength-1:0] angle_next;
    logic [kAngleLength:0]   angle_sum;

    // One extra bit so the last step past kAngle180 cannot wrap back into range.
    assign angle_sum = {1'b0, angle} + (kAngleLength + 1)'(kAngleStep);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            angle <= '0;
        end else begin
            state <= state_next;
            angle <= angle_next;
        end
    end

    // Handshake: an angle transfers on the rising edge where angle_valid && proc_ready;
    // angle stays frozen while angle_valid is high and proc_done only counts in WAIT.
    always_comb begin
        state_next = state;
        angle_next = angle;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETUP;
                    angle_next = '0;
                end
            end
            S_SETUP:  state_next = S_ISSUE;
            S_ISSUE:  if (proc_ready) state_next = S_WAIT;
            S_WAIT:   if (proc_done) state_next = S_NEXT;
            S_NEXT: begin
                if (angle_sum >= (kAngleLength + 1)'(kAngle180)) begin
                    state_next = S_FINISH;
                end else begin
                    angle_next = angle_sum[kAngleLength-1:0];
                    state_next = S_SETUP;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign angle_valid = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FINISH);

endmodule

// File: tb/tb_angle_sequencer.sv
// Directed bench: table-driven sweep on a step-50 instance plus hand-written sweeps on a step-45 instance.
module tb_angle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start       [2];
    logic       proc_ready  [2];
    logic       proc_done   [2];
    logic [9:0] angle       [2];
    logic       angle_valid [2];
    logic       busy        [2];
    logic       done        [2];

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    typedef struct {
        logic st;
        logic rdy;
        logic pd;
        int   ang;
        logic vld;
        logic bsy;
        logic dn;
    } vec_t;

    vec_t tbl[20];

    always #5 clk = ~clk;

    angle_sequencer #(.kAngleLength(10), .kAngleStep(45), .kAngle180(180)) dut45 (
        .clk(clk), .reset(reset), .start(start[0]), .proc_ready(proc_ready[0]),
        .proc_done(proc_done[0]), .angle(angle[0]), .angle_valid(angle_valid[0]),
        .busy(busy[0]), .done(done[0])
    );

    angle_sequencer #(.kAngleLength(10), .kAngleStep(50), .kAngle180(180)) dut50 (
        .clk(clk), .reset(reset), .start(start[1]), .proc_ready(proc_ready[1]),
        .proc_done(proc_done[1]), .angle(angle[1]), .angle_valid(angle_valid[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rdy, input logic pd,
                                input int ang, input logic vld, input logic bsy, input logic dn);
        vec_t v;
        v.st = st; v.rdy = rdy; v.pd = pd; v.ang = ang; v.vld = vld; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    task automatic check_idle(input int idx, input string tag);
        chk({tag, ".angle"}, 32'(angle[idx]), 0);
        chk({tag, ".angle_valid"}, 32'(angle_valid[idx]), 0);
        chk({tag, ".busy"}, 32'(busy[idx]), 0);
        chk({tag, ".done"}, 32'(done[idx]), 0);
    endtask

    task automatic check_q(input string tag);
        chk({tag, ".count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, ".angle"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    // Runs one sweep on the step-45 instance; caller sits on a negedge with the DUT idle.
    task automatic sweep(input int stall_at, input int abort_at, output int done_cyc, output int dn_cnt);
        logic hs_prev;
        int   stalls;
        int   cyc;
        bit   fin;
        hs_prev = 1'b0; stalls = 0; cyc = 0; fin = 1'b0;
        done_cyc = 0; dn_cnt = 0;
        got_q.delete();
        start[0] = 1'b1; proc_ready[0] = 1'b1; proc_done[0] = 1'b0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start[0]     = 1'b0;
            proc_done[0] = hs_prev;
            if (hs_prev && abort_at >= 0 && 32'(angle[0]) == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                proc_done[0] = 1'b0;
                check_idle(0, "abort");
                fin = 1'b1;
            end else begin
                if (done[0]) begin
                    dn_cnt++;
                    done_cyc = cyc;
                end
                if (!busy[0] && cyc > 1) fin = 1'b1;
                if (stalls > 0 && stalls <= 5) begin
                    chk("stall.angle_valid", 32'(angle_valid[0]), 1);
                    chk("stall.angle", 32'(angle[0]), 32'(stall_at));
                end
                if (angle_valid[0] && 32'(angle[0]) == stall_at && stalls < 5) begin
                    proc_ready[0] = 1'b0;
                    stalls++;
                end else begin
                    proc_ready[0] = 1'b1;
                    if (stalls == 5) stalls = 6;
                end
                hs_prev = angle_valid[0] & proc_ready[0];
                if (hs_prev) got_q.push_back(angle[0]);
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL sweep_timeout actual=%0d required=<300", cyc);
        end
        proc_done[0] = 1'b0;
    endtask

    initial begin
        int dc;
        int dn;

        tbl[0]  = mk(1, 1, 0,   0, 0, 0, 0);  // IDLE, start
        tbl[1]  = mk(1, 1, 1,   0, 0, 1, 0);  // SETUP, spurious start/done
        tbl[2]  = mk(1, 1, 1,   0, 1, 1, 0);  // ISSUE, handshake with done ignored
        tbl[3]  = mk(0, 1, 1,   0, 0, 1, 0);  // WAIT
        tbl[4]  = mk(1, 1, 1,   0, 0, 1, 0);  // NEXT
        tbl[5]  = mk(0, 1, 0,  50, 0, 1, 0);
        tbl[6]  = mk(0, 1, 0,  50, 1, 1, 0);
        tbl[7]  = mk(0, 1, 1,  50, 0, 1, 0);
        tbl[8]  = mk(0, 1, 0,  50, 0, 1, 0);
        tbl[9]  = mk(0, 1, 0, 100, 0, 1, 0);
        tbl[10] = mk(0, 1, 0, 100, 1, 1, 0);
        tbl[11] = mk(0, 1, 1, 100, 0, 1, 0);
        tbl[12] = mk(0, 1, 0, 100, 0, 1, 0);
        tbl[13] = mk(0, 1, 0, 150, 0, 1, 0);
        tbl[14] = mk(0, 1, 0, 150, 1, 1, 0);
        tbl[15] = mk(0, 1, 1, 150, 0, 1, 0);
        tbl[16] = mk(0, 1, 0, 150, 0, 1, 0);  // NEXT: 200 >= 180
        tbl[17] = mk(1, 1, 0, 150, 0, 1, 1);  // FINISH, start ignored
        tbl[18] = mk(0, 1, 0, 150, 0, 0, 0);
        tbl[19] = mk(0, 1, 0, 150, 0, 0, 0);

        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; proc_ready[k] = 1'b0; proc_done[k] = 1'b0;
        end
        reset = 1'b1;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle(0, "reset45");
            check_idle(1, "reset50");
        end
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            chk($sformatf("tbl[%0d].angle", i), 32'(angle[1]), 32'(tbl[i].ang));
            chk($sformatf("tbl[%0d].angle_valid", i), 32'(angle_valid[1]), 32'(tbl[i].vld));
            chk($sformatf("tbl[%0d].busy", i), 32'(busy[1]), 32'(tbl[i].bsy));
            chk($sformatf("tbl[%0d].done", i), 32'(done[1]), 32'(tbl[i].dn));
            start[1] = tbl[i].st; proc_ready[1] = tbl[i].rdy; proc_done[1] = tbl[i].pd;
            @(negedge clk);
        end
        start[1] = 1'b0; proc_ready[1] = 1'b0; proc_done[1] = 1'b0;

        sweep(-1, -1, dc, dn);
        exp_q.push_back(10'd0); exp_q.push_back(10'd45); exp_q.push_back(10'd90); exp_q.push_back(10'd135);
        check_q("sweep45");
        chk("sweep45.done_count", 32'(dn), 1);
        chk("sweep45.done_cycle", 32'(dc), 17);

        sweep(90, -1, dc, dn);
        exp_q.push_back(10'd0); exp_q.push_back(10'd45); exp_q.push_back(10'd90); exp_q.push_back(10'd135);
        check_q("stall45");
        chk("stall45.done_count", 32'(dn), 1);
        chk("stall45.done_cycle", 32'(dc), 22);

        sweep(-1, 90, dc, dn);
        exp_q.push_back(10'd0); exp_q.push_back(10'd45); exp_q.push_back(10'd90);
        check_q("abort45");
        chk("abort45.done_count", 32'(dn), 0);
        @(negedge clk);
        check_idle(0, "abort45.after");

        sweep(-1, -1, dc, dn);
        exp_q.push_back(10'd0); exp_q.push_back(10'd45); exp_q.push_back(10'd90); exp_q.push_back(10'd135);
        check_q("restart45");
        chk("restart45.done_count", 32'(dn), 1);
        chk("restart45.done_cycle", 32'(dc), 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/angle_sequencer.md
ANGLE_SEQUENCER -- requirements
Module: angle_sequencer

Interface
REQ-001 SHALL have parameter kAngleLength, default 10, width of the angle bus.
REQ-002 SHALL have parameter kAngleStep, default 1, angle increment per projection; legal range 1..kAngle180-1.
REQ-003 SHALL have parameter kAngle180, default 180, exclusive upper angle bound.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous and active-high.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a full angle sweep.
REQ-007 SHALL have port proc_ready, input, 1, downstream ready to accept the next angle.
REQ-008 SHALL have port proc_done, input, 1, single-cycle pulse: downstream finished the current angle.
REQ-009 SHALL have port angle, output, kAngleLength, current angle; mode control consumes it combinationally.
REQ-010 SHALL have port angle_valid, output, 1, angle is stable and offered downstream.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, single-cycle pulse at sweep completion.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ISSUE, WAIT, NEXT and FINISH.
REQ-014 IDLE SHALL go to SETUP on start=1 and load angle with 0; otherwise it stays in IDLE.
REQ-015 SHALL stay in SETUP for exactly 1 cycle, so the combinational sector/mode decode settles before the angle is offered, then go to ISSUE.
REQ-016 SHALL hold angle_valid=1 only in ISSUE; it goes to WAIT on the first cycle with proc_ready=1 (handshake = angle_valid & proc_ready).
REQ-017 SHALL hold angle constant from SETUP entry until NEXT; it never changes while angle_valid=1.
REQ-018 SHALL stay in WAIT until proc_done=1, then go to NEXT.
REQ-019 NEXT SHALL compute angle+kAngleStep at kAngleLength+1 bits with no truncation; if the result >= kAngle180, go to FINISH with angle unchanged, else load the result and go to SETUP.
REQ-020 FINISH SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-021 Sweep length SHALL be ceil(kAngle180/kAngleStep) handshakes.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 proc_done outside WAIT SHALL be ignored.
REQ-024 proc_done=1 in the same cycle as the ISSUE handshake SHALL be ignored; only a proc_done in WAIT counts.
REQ-025 start=1 in the FINISH cycle SHALL be ignored; a new sweep needs start in IDLE.
REQ-026 Minimum per-angle latency SHALL be 4 cycles (SETUP, ISSUE, WAIT, NEXT), given proc_ready=1 and proc_done on the first WAIT cycle.
REQ-027 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, angle=0, angle_valid=0, busy=0, done=0.
REQ-029 Reset SHALL take priority over all inputs, including mid-sweep and in the cycle where done would pulse; no done pulse is emitted after an aborted sweep.

Structure
REQ-030 State encodings and kAngleLength, kAngleStep and kAngle180 SHALL come from the shared NABP configuration package, the same source as the kAngle45/90/135 defines.
REQ-031 No sub-module is required; sector/mode decode stays in the existing mode-control block, which instantiates alongside this block on the angle bus.

Verification
REQ-032 Reset state: assert reset 3 cycles -> angle=0, angle_valid=0, busy=0, done=0; ISSUE is never entered.
REQ-033 Full sweep with kAngleStep=45, proc_ready=1, proc_done 1 cycle after the handshake -> angles 0, 45, 90, 135 issued once each; done pulses once; total 4x4+1 cycles from start to done.
REQ-034 Non-divisor step, kAngleStep=50 -> angles 0, 50, 100, 150; no angle 200 is issued; done pulses once.
REQ-035 Backpressure: proc_ready=0 for 5 cycles in ISSUE at angle=90 -> angle_valid held high, angle stays 90, no advance.
REQ-036 Spurious inputs: start and proc_done pulsed during SETUP and ISSUE -> no state change, sweep order unchanged.
REQ-037 Mid-sweep reset: reset in WAIT at angle=90 -> next cycle IDLE, angle=0, no done; a new start restarts from 0.
